// File: rtl/uv_apb_timer_pkg.sv
// Shared register offsets, bit positions and the decoded register index
// type for the uv_apb_timer APB peripheral.
package uv_apb_timer_pkg;

  localparam logic [4:0] TMR_CTRL_OFS = 5'h00;
  localparam logic [4:0] TMR_PSC_OFS  = 5'h04;
  localparam logic [4:0] TMR_CNT_OFS  = 5'h08;
  localparam logic [4:0] TMR_CMP_OFS  = 5'h0C;
  localparam logic [4:0] TMR_STAT_OFS = 5'h10;

  localparam int TMR_CTRL_EN = 0;
  localparam int TMR_CTRL_AR = 1;
  localparam int TMR_CTRL_IE = 2;
  localparam int TMR_CTRL_W  = 3;
  localparam int TMR_STAT_MF = 0;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_PSC,
    REG_CNT,
    REG_CMP,
    REG_STAT,
    REG_NONE
  } tmr_reg_e;

  // Word index paddr[4:2] to register; the byte offset inside a word is ignored.
  function automatic tmr_reg_e tmr_decode(input logic [2:0] word);
    case ({word, 2'b00})
      TMR_CTRL_OFS: return REG_CTRL;
      TMR_PSC_OFS:  return REG_PSC;
      TMR_CNT_OFS:  return REG_CNT;
      TMR_CMP_OFS:  return REG_CMP;
      TMR_STAT_OFS: return REG_STAT;
      default:      return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uv_timer_prescaler.sv
// Prescaler for uv_apb_timer: emits a one-cycle tick every (psc+1) enabled
// cycles; the count is held at zero while disabled and restarts on a PSC write.
module uv_timer_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  input  logic             psc_wr,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt_q;
  logic [PSC_W-1:0] psc_cnt_d;

  always_comb begin
    tick      = en && (psc_cnt_q == psc);
    psc_cnt_d = psc_cnt_q + PSC_W'(1);
    if (!en || psc_wr || tick) begin
      psc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/uv_apb_timer.sv
// APB timer: prescaled up-counter with compare match, optional auto-reload,
// sticky match flag and level interrupt. Optional error responses: UV_APB_TIMER_PSLVERR_EN.
module uv_apb_timer
  import uv_apb_timer_pkg::*;
#(
  parameter int ALEN  = 12,
  parameter int DLEN  = 32,
  parameter int MLEN  = DLEN / 8,
  parameter int PSC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            apb_psel,
  input  logic            apb_penable,
  input  logic [2:0]      apb_pprot,
  input  logic [ALEN-1:0] apb_paddr,
  input  logic [MLEN-1:0] apb_pstrb,
  input  logic            apb_pwrite,
  input  logic [DLEN-1:0] apb_pwdata,
  output logic [DLEN-1:0] apb_prdata,
  output logic            apb_pready,
  output logic            apb_pslverr,
  output logic            tmr_irq
);

  logic [TMR_CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [PSC_W-1:0]      psc_q, psc_d;
  logic [DLEN-1:0]       cnt_q, cnt_d;
  logic [DLEN-1:0]       cmp_q, cmp_d;
  logic                  mf_q, mf_d;

  logic            access;
  logic            err;
  logic            wr_en;
  logic            rd_en;
  logic            psc_wr;
  logic            tick;
  logic            match;
  tmr_reg_e        reg_sel;
  logic [DLEN-1:0] wmask;
  logic [DLEN-1:0] rdata;
  logic            unused_ok;

  assign unused_ok = ^{apb_pprot, apb_paddr[ALEN-1:5], apb_paddr[1:0]};

  for (genvar gi = 0; gi < MLEN; gi++) begin : g_lane
    assign wmask[gi*8 +: 8] = {8{apb_pstrb[gi]}};
  end

  assign access  = apb_psel && apb_penable;
  assign reg_sel = tmr_decode(apb_paddr[4:2]);

`ifdef UV_APB_TIMER_PSLVERR_EN
  assign err = access && ((reg_sel == REG_NONE) || (apb_pwrite && (apb_pstrb == '0)));
`else
  assign err = 1'b0;
`endif

  assign wr_en  = access && apb_pwrite && !err;
  assign rd_en  = access && !apb_pwrite && !err && rst_n;
  assign psc_wr = wr_en && (reg_sel == REG_PSC) && (|wmask[PSC_W-1:0]);
  assign match  = (cnt_q == cmp_q);

  uv_timer_prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ctrl_q[TMR_CTRL_EN]),
    .psc    (psc_q),
    .psc_wr (psc_wr),
    .tick   (tick)
  );

  // Ordering sets priority: W1C < match set, and tick update < software write.
  always_comb begin
    ctrl_d = ctrl_q;
    psc_d  = psc_q;
    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    mf_d   = mf_q;

    if (wr_en && (reg_sel == REG_STAT) && apb_pstrb[0] && apb_pwdata[TMR_STAT_MF]) begin
      mf_d = 1'b0;
    end

    if (tick) begin
      if (match) begin
        mf_d  = 1'b1;
        cnt_d = '0;
        if (!ctrl_q[TMR_CTRL_AR]) begin
          ctrl_d[TMR_CTRL_EN] = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + DLEN'(1);
      end
    end

    if (wr_en) begin
      case (reg_sel)
        REG_CTRL: begin
          if (apb_pstrb[0]) begin
            ctrl_d = apb_pwdata[TMR_CTRL_W-1:0];
          end
        end
        REG_PSC: begin
          psc_d = (psc_q & ~wmask[PSC_W-1:0]) | (apb_pwdata[PSC_W-1:0] & wmask[PSC_W-1:0]);
        end
        REG_CNT: begin
          if (|apb_pstrb) begin
            cnt_d = (cnt_q & ~wmask) | (apb_pwdata & wmask);
          end
        end
        REG_CMP: begin
          cmp_d = (cmp_q & ~wmask) | (apb_pwdata & wmask);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      psc_q  <= '0;
      cnt_q  <= '0;
      cmp_q  <= '0;
      mf_q   <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      psc_q  <= psc_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      mf_q   <= mf_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: rdata[TMR_CTRL_W-1:0] = ctrl_q;
      REG_PSC:  rdata[PSC_W-1:0]      = psc_q;
      REG_CNT:  rdata                 = cnt_q;
      REG_CMP:  rdata                 = cmp_q;
      REG_STAT: rdata[TMR_STAT_MF]    = mf_q;
      default:  rdata                 = '0;
    endcase
  end

  // Gated by rst_n so an access abandoned by reset returns zero and no error.
  assign apb_prdata  = rd_en ? rdata : '0;
  assign apb_pready  = 1'b1;
  assign apb_pslverr = err && rst_n;
  assign tmr_irq     = mf_q && ctrl_q[TMR_CTRL_IE];

endmodule

// File: tb/tb_uv_apb_timer.sv
// Directed bench for uv_apb_timer: register table plus timed corner-case sequences.
module tb_uv_apb_timer;

`ifdef UV_APB_TIMER_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [11:0] A_CTRL = 12'h000;
  localparam logic [11:0] A_PSC  = 12'h004;
  localparam logic [11:0] A_CNT  = 12'h008;
  localparam logic [11:0] A_CMP  = 12'h00C;
  localparam logic [11:0] A_STAT = 12'h010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [2:0]  pprot = 3'b000;
  logic [11:0] paddr = '0;
  logic [3:0]  pstrb = '0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uv_apb_timer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .apb_psel    (psel),
    .apb_penable (penable),
    .apb_pprot   (pprot),
    .apb_paddr   (paddr),
    .apb_pstrb   (pstrb),
    .apb_pwrite  (pwrite),
    .apb_pwdata  (pwdata),
    .apb_prdata  (prdata),
    .apb_pready  (pready),
    .apb_pslverr (pslverr),
    .tmr_irq     (irq)
  );

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic        err;
    string       name;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [31:0] exp, input logic err,
                              input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
    v.exp = exp; v.err = err; v.name = name;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, act);
    end
  endtask

  // Setup after the next edge, access after the one after, commit on the third.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    #3 e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = '0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #3;
    d = prdata;
    e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, 4'hF, e);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_read(a, d, e);
    chk(name, d, exp);
  endtask

  // Cycles (edges) from the call until tmr_irq is seen high; 0 if the bound expires.
  task automatic wait_irq(input int max_cyc, output int c);
    bit seen;
    seen = 1'b0;
    c = 0;
    for (int i = 1; i <= max_cyc && !seen; i++) begin
      @(posedge clk); #1;
      if (irq) begin
        c = i;
        seen = 1'b1;
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          c;
    logic [11:0] all_regs[5];

    all_regs[0] = A_CTRL; all_regs[1] = A_PSC; all_regs[2] = A_CNT;
    all_regs[3] = A_CMP;  all_regs[4] = A_STAT;

    vecs[0]  = mk(1, A_CMP,   32'hAABBCCDD, 4'b0101, 32'h0,        0, "w_cmp_strb");
    vecs[1]  = mk(0, A_CMP,   32'h0,        4'b0000, 32'h00BB00DD, 0, "cmp_strb");
    vecs[2]  = mk(1, A_PSC,   32'h12345678, 4'b1111, 32'h0,        0, "w_psc");
    vecs[3]  = mk(0, A_PSC,   32'h0,        4'b0000, 32'h00005678, 0, "psc_trunc");
    vecs[4]  = mk(1, A_CTRL,  32'hFFFFFFFA, 4'b0001, 32'h0,        0, "w_ctrl");
    vecs[5]  = mk(0, A_CTRL,  32'h0,        4'b0000, 32'h00000002, 0, "ctrl_bits");
    vecs[6]  = mk(1, A_CNT,   32'h11223344, 4'b1100, 32'h0,        0, "w_cnt_strb");
    vecs[7]  = mk(0, A_CNT,   32'h0,        4'b0000, 32'h11220000, 0, "cnt_strb");
    vecs[8]  = mk(0, 12'h014, 32'h0,        4'b0000, 32'h0,        1, "rd_14");
    vecs[9]  = mk(1, 12'h018, 32'hFFFFFFFF, 4'b1111, 32'h0,        1, "w_18");
    vecs[10] = mk(0, 12'h018, 32'h0,        4'b0000, 32'h0,        1, "rd_18");
    vecs[11] = mk(1, A_CTRL,  32'h00000007, 4'b0000, 32'h0,        1, "w_ctrl_nostrb");
    vecs[12] = mk(0, A_CTRL,  32'h0,        4'b0000, 32'h00000002, 0, "ctrl_kept");
    vecs[13] = mk(0, 12'h108, 32'h0,        4'b0000, 32'h11220000, 0, "cnt_alias_hi");
    vecs[14] = mk(0, 12'h00F, 32'h0,        4'b0000, 32'h00BB00DD, 0, "cmp_alias_lo");
    vecs[15] = mk(0, A_STAT,  32'h0,        4'b0000, 32'h0,        0, "stat_idle");
    vecs[16] = mk(1, A_CTRL,  32'h0,        4'b1111, 32'h0,        0, "w_ctrl_off");

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_pready", 32'(pready), 32'h1);
    chk("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) rd_chk($sformatf("rst_reg%0d", i), all_regs[i], 32'h0);

    // Register table (timer stays disabled)
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) begin
        apb_write(vecs[i].addr, vecs[i].data, vecs[i].strb, e);
      end else begin
        apb_read(vecs[i].addr, d, e);
        chk(vecs[i].name, d, vecs[i].exp);
      end
      chk({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].err & ERR_EN));
    end

    // Periodic: first match (4+1)*(3+1) = 20 cycles after enable
    wr(A_CNT, 32'h0); wr(A_CMP, 32'd4); wr(A_PSC, 32'd3); wr(A_CTRL, 32'h7);
    wait_irq(40, c);
    chk("irq_latency", 32'(c), 32'd20);
    rd_chk("cnt_at_match", A_CNT, 32'h0);
    rd_chk("stat_mf", A_STAT, 32'h1);
    rd_chk("cnt_continues", A_CNT, 32'd2);
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h1);
    chk("irq_after_w1c", 32'(irq), 32'h0);
    rd_chk("stat_cleared", A_STAT, 32'h0);

    // W1C landing on the match edge: set wins
    wr(A_PSC, 32'h0); wr(A_CNT, 32'h0); wr(A_CMP, 32'd3); wr(A_CTRL, 32'h7);
    @(posedge clk); #1;
    wr(A_STAT, 32'h1);
    chk("irq_w1c_collide", 32'(irq), 32'h1);
    rd_chk("stat_w1c_collide", A_STAT, 32'h1);
    wr(A_CTRL, 32'h0); wr(A_STAT, 32'h1);

    // One-shot: match after 3 cycles, EN auto-cleared, counter halted at 0
    wr(A_CNT, 32'h0); wr(A_CMP, 32'd2); wr(A_CTRL, 32'h5);
    wait_irq(20, c);
    chk("oneshot_latency", 32'(c), 32'd3);
    rd_chk("oneshot_ctrl", A_CTRL, 32'h4);
    rd_chk("oneshot_cnt", A_CNT, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    rd_chk("oneshot_cnt_held", A_CNT, 32'h0);
    wr(A_STAT, 32'h1);

    // CNT write committing on a one-shot match edge: software value wins
    wr(A_CNT, 32'h0); wr(A_CMP, 32'd3); wr(A_CTRL, 32'h1);
    @(posedge clk); #1;
    wr(A_CNT, 32'h10);
    rd_chk("cnt_sw_wins", A_CNT, 32'h10);
    rd_chk("cnt_sw_mf", A_STAT, 32'h1);
    rd_chk("cnt_sw_ctrl", A_CTRL, 32'h0);
    wr(A_STAT, 32'h1);

    // Wrap from all-ones to 0 without MF
    wr(A_CMP, 32'd5); wr(A_CNT, 32'hFFFFFFFF); wr(A_CTRL, 32'h1);
    rd_chk("cnt_wrap", A_CNT, 32'd1);
    rd_chk("wrap_no_mf", A_STAT, 32'h0);
    wr(A_CTRL, 32'h0); wr(A_STAT, 32'h1);

    // Reset during a read access of a live timer
    wr(A_PSC, 32'h0); wr(A_CNT, 32'h0); wr(A_CMP, 32'd1); wr(A_CTRL, 32'h7);
    wait_irq(10, c);
    chk("pre_rst_irq_latency", 32'(c), 32'd2);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_CTRL;
    @(posedge clk); #1;
    penable = 1'b1;
    rst_n = 1'b0;
    #3;
    chk("midrst_prdata", prdata, 32'h0);
    chk("midrst_pslverr", 32'(pslverr), 32'h0);
    chk("midrst_pready", 32'(pready), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    chk("midrst_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 5; i++) rd_chk($sformatf("midrst_reg%0d", i), all_regs[i], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
